// File: rtl/dl_port_pkg.sv
// Shared types for the download-port responder: posted-write entry, FSM states and byte merge.
// The merge helper is only used when DL_BYTE_MERGE_EN is defined.
package dl_port_pkg;

  localparam int unsigned DL_AW = 23;
  localparam logic [1:0]  DL_DS_NONE = 2'b00;

  typedef struct packed {
    logic [DL_AW-1:0] a;
    logic [1:0]       ds;
    logic [15:0]      d;
  } dl_entry_t;

  typedef enum logic [1:0] {IDLE, WR, RD, RDW} dl_state_e;

  function automatic dl_entry_t dl_merge_bytes(dl_entry_t e, logic [1:0] ds, logic [15:0] d);
    dl_entry_t r;
    r    = e;
    r.ds = e.ds | ds;
    if (ds[1]) r.d[15:8] = d[15:8];
    if (ds[0]) r.d[7:0]  = d[7:0];
    return r;
  endfunction

endpackage

// File: rtl/dl_wr_fifo.sv
// Posted-write FIFO of dl_entry_t with wrap-bit pointers.
// DL_BYTE_MERGE_EN adds a tail output and a port that ORs new bytes into the tail entry.
module dl_wr_fifo
  import dl_port_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    push,
  input  dl_entry_t               push_data,
  input  logic                    pop,
`ifdef DL_BYTE_MERGE_EN
  input  logic                    merge,
  input  logic [1:0]              merge_ds,
  input  logic [15:0]             merge_d,
  output dl_entry_t               tail,
`endif
  output dl_entry_t               head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned   IdxW   = $clog2(DEPTH);
  localparam logic [IdxW:0] PtrOne = {{IdxW{1'b0}}, 1'b1};

  logic [IdxW:0] wptr, rptr;
  dl_entry_t     mem [DEPTH];

  assign head  = mem[rptr[IdxW-1:0]];
  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[IdxW] != rptr[IdxW]) && (wptr[IdxW-1:0] == rptr[IdxW-1:0]);

`ifdef DL_BYTE_MERGE_EN
  logic [IdxW:0] tail_ptr;
  assign tail_ptr = wptr - PtrOne;
  assign tail     = mem[tail_ptr[IdxW-1:0]];
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PtrOne;
      if (pop)  rptr <= rptr + PtrOne;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wptr[IdxW-1:0]] <= push_data;
`ifdef DL_BYTE_MERGE_EN
    if (merge) mem[tail_ptr[IdxW-1:0]] <= dl_merge_bytes(tail, merge_ds, merge_d);
`endif
  end

endmodule

// File: rtl/dl_port_responder.sv
// Toggle req/ack memory port responder: posts writes through dl_wr_fifo, serialises reads behind
// them, and drives a single-word memory command bus. DL_BYTE_MERGE_EN enables tail byte merging.
module dl_port_responder
  import dl_port_pkg::*;
#(
  parameter int unsigned AW    = DL_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          port_req,
  output logic          port_ack,
  input  logic [AW-1:0] port_a,
  input  logic [1:0]    port_ds,
  input  logic          port_we,
  input  logic [15:0]   port_d,
  output logic [15:0]   port_q,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_d,
  input  logic          mem_gnt,
  input  logic          mem_rdvalid,
  input  logic [15:0]   mem_q
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  dl_state_e       state_q, state_d;
  logic            req_seen;
  logic            pending, ds_none, merge_ok;
  logic            wr_take, rd_take, push, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  dl_entry_t       head, wr_entry;

  assign pending  = port_req ^ req_seen;
  assign ds_none  = (port_ds == DL_DS_NONE);
  assign wr_entry = '{a: port_a, ds: port_ds, d: port_d};

`ifdef DL_BYTE_MERGE_EN
  logic      merge;
  dl_entry_t tail;
  // Two or more entries guarantee the tail is neither presented nor about to be loaded as head.
  assign merge_ok = (fifo_count >= CntW'(2)) && (tail.a == port_a) &&
                    ((tail.ds & port_ds) == DL_DS_NONE);
  assign merge    = wr_take & ~ds_none & merge_ok;
`else
  assign merge_ok = 1'b0;
`endif

  assign wr_take = pending & port_we & (ds_none | merge_ok | ~fifo_full);
  assign push    = wr_take & ~ds_none & ~merge_ok;
  assign rd_take = pending & ~port_we & fifo_empty & (state_q == IDLE);
  assign pop     = (state_q == WR) & mem_req & mem_gnt;

  dl_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
`ifdef DL_BYTE_MERGE_EN
    .merge     (merge),
    .merge_ds  (port_ds),
    .merge_d   (port_d),
    .tail      (tail),
`endif
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty)  state_d = WR;
        else if (rd_take) state_d = RD;
      end
      WR:  if (pop && fifo_count == CntW'(1)) state_d = IDLE;
      RD:  if (mem_gnt) state_d = RDW;
      RDW: if (mem_rdvalid) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q  <= IDLE;
      req_seen <= port_req;
      port_ack <= port_req;
      port_q   <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_ds   <= '0;
      mem_d    <= '0;
    end else begin
      state_q <= state_d;
      if (wr_take) begin
        req_seen <= ~req_seen;
        port_ack <= ~port_ack;
      end
      if (rd_take) req_seen <= ~req_seen;
      if (state_q == RDW && mem_rdvalid) begin
        port_q   <= mem_q;
        port_ack <= ~port_ack;
      end

      // mem_req always drops on the granting edge; WR reloads the next head a cycle later.
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= head.a;
            mem_ds   <= head.ds;
            mem_d    <= head.d;
          end else if (rd_take) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= port_a;
            mem_ds   <= port_ds;
          end
        end
        WR: begin
          if (mem_req) begin
            if (mem_gnt) mem_req <= 1'b0;
          end else if (!fifo_empty) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= head.a;
            mem_ds   <= head.ds;
            mem_d    <= head.d;
          end
        end
        RD:  if (mem_gnt) mem_req <= 1'b0;
        RDW: mem_req <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dl_port_responder.sv
// Scoreboard bench for dl_port_responder: directed port requests push expected memory commands,
// a negedge monitor grants, pops and compares them. Honours DL_BYTE_MERGE_EN for the merge case.
module tb_dl_port_responder;

  localparam int unsigned AW    = 23;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic [15:0]   d;
  } cmd_t;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          port_req, port_we;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic [15:0]   port_d, port_q;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_ds;
  logic [15:0]   mem_d;
  logic          mem_gnt = 1'b0;
  logic          mem_rdvalid = 1'b0;
  logic [15:0]   mem_q = 16'h0;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  cmd_t exp_q[$];

  logic        gnt_en = 1'b0;
  logic        rdv_en = 1'b1;
  logic        gnt_given = 1'b0;
  int          rdv_cnt = 0;
  int          last_gnt_edge = 0;
  int          rdv_edge = 0;
  logic [15:0] rd_data = 16'h0;

  dl_port_responder #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .port_req    (port_req),
    .port_ack    (port_ack),
    .port_a      (port_a),
    .port_ds     (port_ds),
    .port_we     (port_we),
    .port_d      (port_d),
    .port_q      (port_q),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_ds      (mem_ds),
    .mem_d       (mem_d),
    .mem_gnt     (mem_gnt),
    .mem_rdvalid (mem_rdvalid),
    .mem_q       (mem_q)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Memory side: grant any presented command, compare it with the scoreboard, answer reads.
  always @(negedge clk_sys) begin
    cmd_t got;
    cmd_t e;
    if (gnt_given) check("req_drop_after_gnt", 64'(mem_req), 64'(0));
    mem_gnt     = 1'b0;
    gnt_given   = 1'b0;
    mem_rdvalid = 1'b0;
    if (rdv_cnt > 0) begin
      rdv_cnt--;
      if (rdv_cnt == 0) begin
        mem_rdvalid = 1'b1;
        mem_q       = rd_data;
        rdv_edge    = cyc + 1;
      end
    end
    if (!reset && mem_req && gnt_en) begin
      got = '{we: mem_we, a: mem_addr, ds: mem_ds, d: (mem_we ? mem_d : 16'h0)};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL issue_unexpected: got 0x%0h, expected no command", got);
      end else begin
        e = exp_q.pop_front();
        check("issue", 64'(got), 64'(e));
      end
      mem_gnt       = 1'b1;
      gnt_given     = 1'b1;
      last_gnt_edge = cyc + 1;
      if (!mem_we && rdv_en) rdv_cnt = 2;
    end
  end

  task automatic port_xfer(input logic [AW-1:0] a, input logic [1:0] ds, input logic [15:0] d,
                           input logic we, output int lat, output int ack_edge);
    @(posedge clk_sys); #1;
    port_a   = a;
    port_ds  = ds;
    port_d   = d;
    port_we  = we;
    port_req = ~port_req;
    lat = 0;
    do begin
      @(posedge clk_sys); #1;
      lat++;
    end while (port_ack != port_req && lat < 64);
    ack_edge = cyc;
    if (port_ack != port_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack, expected ack for addr 0x%0h", a);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_req) && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk_sys);
  endtask

  initial begin
    int   lat, ack_e, n;
    logic saw;
    reset    = 1'b1;
    port_req = 1'b1;
    port_we  = 1'b0;
    port_a   = '0;
    port_ds  = 2'b00;
    port_d   = 16'h0;
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;

    // Reset with port_req=1: no request seen, all outputs cleared.
    @(negedge clk_sys);
    check("rst_ack", 64'(port_ack), 64'(1));
    check("rst_port_q", 64'(port_q), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      saw = saw | mem_req;
    end
    check("rst_no_req", 64'(saw), 64'(0));

    // Single write.
    gnt_en = 1'b1;
    exp_q.push_back('{we: 1'b1, a: 23'h10, ds: 2'b01, d: 16'h00AB});
    port_xfer(23'h10, 2'b01, 16'h00AB, 1'b1, lat, ack_e);
    check("wr_lat", 64'(lat), 64'(1));
    wait_drain("wr_single_drain");

    // DEPTH+1 writes with the grant held off; the last one waits for the first pop.
    gnt_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++)
      exp_q.push_back('{we: 1'b1, a: 23'h100 + 23'(i), ds: 2'b11, d: 16'hC000 + 16'(i)});
    for (int i = 0; i < DEPTH; i++) begin
      port_xfer(23'h100 + 23'(i), 2'b11, 16'hC000 + 16'(i), 1'b1, lat, ack_e);
      check("fill_lat", 64'(lat), 64'(1));
    end
    fork
      port_xfer(23'h100 + 23'(DEPTH), 2'b11, 16'hC000 + 16'(DEPTH), 1'b1, lat, ack_e);
      begin
        repeat (6) @(posedge clk_sys);
        gnt_en = 1'b1;
      end
    join
    check("full_ack_after_gnt", 64'(ack_e), 64'(last_gnt_edge + 1));
    wait_drain("full_drain");

    // Read behind a write to the same address.
    gnt_en  = 1'b0;
    rd_data = 16'h1234;
    exp_q.push_back('{we: 1'b1, a: 23'h50, ds: 2'b11, d: 16'h5555});
    port_xfer(23'h50, 2'b11, 16'h5555, 1'b1, lat, ack_e);
    check("wr50_lat", 64'(lat), 64'(1));
    exp_q.push_back('{we: 1'b0, a: 23'h50, ds: 2'b11, d: 16'h0});
    fork
      port_xfer(23'h50, 2'b11, 16'h0, 1'b0, lat, ack_e);
      begin
        repeat (5) @(negedge clk_sys);
        check("rd_blocked_we", 64'(mem_we), 64'(1));
        check("rd_blocked_addr", 64'(mem_addr), 64'(23'h50));
        gnt_en = 1'b1;
      end
    join
    check("rd_port_q", 64'(port_q), 64'(16'h1234));
    check("rd_ack_edge", 64'(ack_e), 64'(rdv_edge));
    wait_drain("rd_drain");

    // Byte merge behind a stalled head.
    gnt_en = 1'b0;
    exp_q.push_back('{we: 1'b1, a: 23'h200, ds: 2'b11, d: 16'h1111});
`ifdef DL_BYTE_MERGE_EN
    exp_q.push_back('{we: 1'b1, a: 23'h7, ds: 2'b11, d: 16'hBBAA});
`else
    exp_q.push_back('{we: 1'b1, a: 23'h7, ds: 2'b01, d: 16'h00AA});
    exp_q.push_back('{we: 1'b1, a: 23'h7, ds: 2'b10, d: 16'hBB00});
`endif
    port_xfer(23'h200, 2'b11, 16'h1111, 1'b1, lat, ack_e);
    port_xfer(23'h7, 2'b01, 16'h00AA, 1'b1, lat, ack_e);
    check("merge_a_lat", 64'(lat), 64'(1));
    port_xfer(23'h7, 2'b10, 16'hBB00, 1'b1, lat, ack_e);
    check("merge_b_lat", 64'(lat), 64'(1));
    gnt_en = 1'b1;
    wait_drain("merge_drain");

    // Write with no strobes: acked, never issued.
    port_xfer(23'h300, 2'b00, 16'hFFFF, 1'b1, lat, ack_e);
    check("ds0_lat", 64'(lat), 64'(1));
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      saw = saw | mem_req;
    end
    check("ds0_no_issue", 64'(saw), 64'(0));

    // Reset while waiting for read data.
    rdv_en = 1'b0;
    exp_q.push_back('{we: 1'b0, a: 23'h60, ds: 2'b01, d: 16'h0});
    @(posedge clk_sys); #1;
    port_we  = 1'b0;
    port_a   = 23'h60;
    port_ds  = 2'b01;
    port_req = ~port_req;
    n = 0;
    while (exp_q.size() != 0 && n < 64) begin
      @(negedge clk_sys);
      n++;
    end
    check("rdw_granted", 64'(exp_q.size()), 64'(0));
    repeat (3) @(negedge clk_sys);
    check("rdw_pending", 64'(port_ack ^ port_req), 64'(1));
    @(posedge clk_sys); #1 reset = 1'b1;
    @(posedge clk_sys); #1 reset = 1'b0;
    @(negedge clk_sys);
    check("rdw_rst_req", 64'(mem_req), 64'(0));
    check("rdw_rst_ack", 64'(port_ack), 64'(port_req));
    check("rdw_rst_q", 64'(port_q), 64'(0));
    rd_data = 16'hDEAD;
    rdv_cnt = 1;
    repeat (3) @(negedge clk_sys);
    check("stray_rdv_ack", 64'(port_ack), 64'(port_req));
    check("stray_rdv_q", 64'(port_q), 64'(0));
    rdv_en = 1'b1;

    // FSM is usable again after the abandoned read.
    exp_q.push_back('{we: 1'b1, a: 23'h70, ds: 2'b10, d: 16'h7700});
    port_xfer(23'h70, 2'b10, 16'h7700, 1'b1, lat, ack_e);
    check("post_rst_lat", 64'(lat), 64'(1));
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
